cp0_timer_unit: RTL and testbench

Parametrised coprocessor-0 for the P7/P8 pipeline: exception/interrupt control with a configurable number of hardware interrupt lines plus an internal Count/Compare timer.
- Sits beside the M stage.
- Takes the M-stage PC, branch-delay flag and exception code.
- Returns the exception request and EPC to the hazard/PC unit.
- Serves mfc0/mtc0 and eret.

---
 rtl/cp0_timer_unit.sv | 178 +++++++++++++++++
 tb/tb_cp0_timer_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/cp0_timer_unit.sv
// Coprocessor-0 for the P7/P8 pipeline: exception/interrupt control beside the M stage,
// with a configurable number of hardware interrupt lines and an optional Count/Compare timer.
module cp0_timer_unit #(
    parameter int unsigned NUM_HWINT = 6,
    parameter bit          TIMER_EN  = 1'b1,
    parameter int unsigned COUNT_DIV = 1,
    parameter logic [31:0] PRID_VAL  = 32'h0000_5000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           rd_addr,
    input  logic [4:0]           wr_addr,
    input  logic [31:0]          wdata,
    input  logic                 we,
    input  logic [31:0]          pc,
    input  logic                 bd,
    input  logic [4:0]           exc_code,
    input  logic [NUM_HWINT-1:0] hwint,
    input  logic                 eret,
    output logic                 req,
    output logic [31:0]          epc,
    output logic [31:0]          rdata,
    output logic                 timer_irq
);

    localparam logic [4:0] AddrCount   = 5'd9;
    localparam logic [4:0] AddrCompare = 5'd11;
    localparam logic [4:0] AddrSr      = 5'd12;
    localparam logic [4:0] AddrCause   = 5'd13;
    localparam logic [4:0] AddrEpc     = 5'd14;
    localparam logic [4:0] AddrPrid    = 5'd15;
    localparam logic [7:0] DivLast     = 8'(COUNT_DIV - 1);

    logic [5:0]  sr_im_q, sr_im_d;
    logic        sr_exl_q, sr_exl_d;
    logic        sr_ie_q, sr_ie_d;
    logic        cause_bd_q, cause_bd_d;
    logic [5:0]  cause_ip_q, cause_ip_d;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic        ti_q, ti_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [7:0]  div_q, div_d;

    logic [5:0]  hw_ext;
    logic [5:0]  pend;
    logic        int_req;
    logic        exc_req;
    logic        wr_count, wr_compare, wr_sr, wr_epc;
    logic [31:0] count_inc;
    logic        unused_pc;

    assign unused_pc = ^pc[1:0];

    always_comb begin
        hw_ext                = '0;
        hw_ext[NUM_HWINT-1:0] = hwint;
        pend                  = hw_ext;
        pend[5]               = hw_ext[5] | ti_q;
    end

    assign int_req = (|(pend & sr_im_q)) & sr_ie_q & ~sr_exl_q;
    assign exc_req = (exc_code != 5'd0) & ~sr_exl_q;
    assign req     = int_req | exc_req;

    assign wr_count   = we && (wr_addr == AddrCount);
    assign wr_compare = we && (wr_addr == AddrCompare);
    assign wr_sr      = we && (wr_addr == AddrSr);
    assign wr_epc     = we && (wr_addr == AddrEpc);
    assign count_inc  = count_q + 32'd1;

    always_comb begin
        sr_im_d     = sr_im_q;
        sr_exl_d    = sr_exl_q;
        sr_ie_d     = sr_ie_q;
        cause_bd_d  = cause_bd_q;
        cause_exc_d = cause_exc_q;
        cause_ip_d  = pend;
        epc_d       = epc_q;

        if (wr_sr) begin
            sr_im_d  = wdata[15:10];
            sr_exl_d = wdata[1];
            sr_ie_d  = wdata[0];
        end
        if (wr_epc) begin
            epc_d = wdata;
        end
        if (eret) begin
            sr_exl_d = 1'b0;
        end
        // Exception entry overrides any same-cycle mtc0 of EPC/EXL and any eret.
        if (req) begin
            sr_exl_d    = 1'b1;
            cause_bd_d  = bd;
            cause_exc_d = int_req ? 5'd0 : exc_code;
            epc_d       = bd ? {pc[31:2] - 30'd1, 2'b00} : {pc[31:2], 2'b00};
        end
    end

    always_comb begin
        count_d   = count_q;
        compare_d = compare_q;
        div_d     = div_q;
        ti_d      = ti_q;

        if (TIMER_EN) begin
            if (wr_count) begin
                count_d = wdata;
                div_d   = 8'd0;
            end else if (div_q == DivLast) begin
                div_d   = 8'd0;
                count_d = count_inc;
                if (count_inc == compare_q) begin
                    ti_d = 1'b1;
                end
            end else begin
                div_d = div_q + 8'd1;
            end
            // Compare write acknowledges the timer and beats a same-cycle match.
            if (wr_compare) begin
                compare_d = wdata;
                ti_d      = 1'b0;
            end
        end else begin
            count_d   = '0;
            compare_d = '0;
            div_d     = '0;
            ti_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im_q     <= '0;
            sr_exl_q    <= 1'b0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= '0;
            cause_exc_q <= '0;
            ti_q        <= 1'b0;
            epc_q       <= '0;
            count_q     <= '0;
            compare_q   <= '0;
            div_q       <= '0;
        end else begin
            sr_im_q     <= sr_im_d;
            sr_exl_q    <= sr_exl_d;
            sr_ie_q     <= sr_ie_d;
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= cause_ip_d;
            cause_exc_q <= cause_exc_d;
            ti_q        <= ti_d;
            epc_q       <= epc_d;
            count_q     <= count_d;
            compare_q   <= compare_d;
            div_q       <= div_d;
        end
    end

    assign epc       = epc_q;
    assign timer_irq = ti_q;

    always_comb begin
        rdata = '0;
        unique case (rd_addr)
            AddrCount:   rdata = count_q;
            AddrCompare: rdata = compare_q;
            AddrSr:      rdata = {16'h0, sr_im_q, 8'h0, sr_exl_q, sr_ie_q};
            AddrCause:   rdata = {cause_bd_q, ti_q, 14'h0, cause_ip_q, 3'h0, cause_exc_q, 2'h0};
            AddrEpc:     rdata = epc_q;
            AddrPrid:    rdata = PRID_VAL;
            default:     rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_timer_unit.sv
// Directed self-checking bench for cp0_timer_unit (timer divider set to 2).
module tb_cp0_timer_unit;

    logic        clk;
    logic        reset;
    logic [4:0]  rd_addr;
    logic [4:0]  wr_addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc_code;
    logic [5:0]  hwint;
    logic        eret;
    logic        req;
    logic [31:0] epc;
    logic [31:0] rdata;
    logic        timer_irq;

    int n_checks = 0;
    int n_fail   = 0;

    cp0_timer_unit #(
        .NUM_HWINT(6),
        .TIMER_EN (1'b1),
        .COUNT_DIV(2),
        .PRID_VAL (32'h0000_5000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .wr_addr  (wr_addr),
        .wdata    (wdata),
        .we       (we),
        .pc       (pc),
        .bd       (bd),
        .exc_code (exc_code),
        .hwint    (hwint),
        .eret     (eret),
        .req      (req),
        .epc      (epc),
        .rdata    (rdata),
        .timer_irq(timer_irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        we      = 1'b1;
        wr_addr = addr;
        wdata   = data;
        step();
        we      = 1'b0;
    endtask

    task automatic rd(input logic [4:0] addr, output logic [31:0] v);
        rd_addr = addr;
        #1;
        v = rdata;
    endtask

    logic [31:0] v;

    initial begin
        reset = 1'b1; rd_addr = '0; wr_addr = '0; wdata = '0; we = 1'b0;
        pc = '0; bd = 1'b0; exc_code = '0; hwint = '0; eret = 1'b0;
        step();
        step();
        check_eq("rst_req", {31'b0, req}, 32'd0);
        check_eq("rst_epc", epc, 32'd0);
        check_eq("rst_ti", {31'b0, timer_irq}, 32'd0);
        reset = 1'b0;
        rd(5'd12, v); check_eq("rst_sr", v, 32'd0);
        rd(5'd13, v); check_eq("rst_cause", v, 32'd0);
        rd(5'd11, v); check_eq("rst_compare", v, 32'd0);
        rd(5'd15, v); check_eq("prid", v, 32'h0000_5000);

        // Interrupt entry
        mtc0(5'd12, 32'h0000_0401);
        hwint = 6'b000001; pc = 32'h3010; bd = 1'b0;
        #1 check_eq("t1_req", {31'b0, req}, 32'd1);
        step();
        check_eq("t1_epc", epc, 32'h3010);
        check_eq("t1_req_off", {31'b0, req}, 32'd0);
        rd(5'd12, v); check_eq("t1_sr", v, 32'h0000_0403);
        rd(5'd13, v); check_eq("t1_cause", v, 32'h0000_0400);

        // eret with interrupt still pending
        eret = 1'b1;
        #1 check_eq("t4_req_exl", {31'b0, req}, 32'd0);
        step();
        eret = 1'b0;
        #1 check_eq("t4_req_again", {31'b0, req}, 32'd1);
        rd(5'd12, v); check_eq("t4_sr_clr", v, 32'h0000_0401);
        step();
        hwint = 6'b0;
        mtc0(5'd12, 32'h0000_0001);
        rd(5'd12, v); check_eq("t2_sr", v, 32'h0000_0001);

        // Delay-slot exception
        exc_code = 5'd12; pc = 32'h3024; bd = 1'b1;
        #1 check_eq("t2_req", {31'b0, req}, 32'd1);
        step();
        exc_code = 5'd0; bd = 1'b0;
        check_eq("t2_epc", epc, 32'h3020);
        rd(5'd13, v); check_eq("t2_cause", v, 32'h8000_0030);
        rd(5'd12, v); check_eq("t2_sr_exl", v, 32'h0000_0003);
        eret = 1'b1;
        step();
        eret = 1'b0;
        rd(5'd12, v); check_eq("t2_eret", v, 32'h0000_0001);

        // Interrupt beats exception
        mtc0(5'd12, 32'h0000_1001);
        hwint = 6'b000100; exc_code = 5'd4; pc = 32'h3100;
        #1 check_eq("t3_req", {31'b0, req}, 32'd1);
        step();
        exc_code = 5'd0;
        rd(5'd13, v); check_eq("t3_cause", v, 32'h0000_1000);
        check_eq("t3_epc", epc, 32'h3100);
        hwint = 6'b0;
        eret = 1'b1;
        step();
        eret = 1'b0;

        // eret and exception in the same cycle
        eret = 1'b1; exc_code = 5'd10; pc = 32'h3200;
        #1 check_eq("t4b_req", {31'b0, req}, 32'd1);
        step();
        eret = 1'b0; exc_code = 5'd0;
        rd(5'd12, v); check_eq("t4b_sr", v, 32'h0000_1003);
        rd(5'd13, v); check_eq("t4b_cause", v, 32'h0000_0028);
        check_eq("t4b_epc", epc, 32'h3200);
        eret = 1'b1;
        step();
        eret = 1'b0;
        rd(5'd12, v); check_eq("t4b_eret", v, 32'h0000_1001);

        // Timer, divide by 2
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd11, 32'd5);
        pc = 32'h3300;
        mtc0(5'd9, 32'd0);
        repeat (9) step();
        check_eq("t5_ti_early", {31'b0, timer_irq}, 32'd0);
        rd(5'd9, v); check_eq("t5_count4", v, 32'd4);
        step();
        check_eq("t5_ti_set", {31'b0, timer_irq}, 32'd1);
        check_eq("t5_req", {31'b0, req}, 32'd1);
        rd(5'd9, v); check_eq("t5_count5", v, 32'd5);
        step();
        rd(5'd13, v); check_eq("t5_cause", v, 32'h4000_8000);
        check_eq("t5_epc", epc, 32'h3300);
        check_eq("t5_req_off", {31'b0, req}, 32'd0);
        mtc0(5'd11, 32'd100);
        check_eq("t5_ti_clr", {31'b0, timer_irq}, 32'd0);
        rd(5'd11, v); check_eq("t5_compare", v, 32'd100);

        // Re-arm TI, then reset mid-operation
        mtc0(5'd11, 32'd1);
        mtc0(5'd9, 32'd0);
        step();
        step();
        check_eq("t6_ti_rearm", {31'b0, timer_irq}, 32'd1);
        mtc0(5'd9, 32'h1234);
        rd(5'd9, v); check_eq("t6_count", v, 32'h1234);
        check_eq("t6_ti_hold", {31'b0, timer_irq}, 32'd1);
        rd(5'd12, v); check_eq("t6_sr_exl", v, 32'h0000_8003);
        reset = 1'b1;
        step();
        check_eq("t6_req", {31'b0, req}, 32'd0);
        check_eq("t6_epc", epc, 32'd0);
        check_eq("t6_ti", {31'b0, timer_irq}, 32'd0);
        rd(5'd9, v);  check_eq("t6_count0", v, 32'd0);
        rd(5'd13, v); check_eq("t6_cause", v, 32'd0);
        rd(5'd12, v); check_eq("t6_sr", v, 32'd0);
        rd(5'd11, v); check_eq("t6_compare", v, 32'd0);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
